// File: rtl/simple_processor_pkg.sv
// simple_processor_pkg: shared types and sizing for the simple processor.
//   DATA_WIDTH     - datapath / register width
//   NUM_REGS       - architectural register count (x0 reads as zero)
//   REG_ADDR_WIDTH - register address width
//   IMM_WIDTH      - shift immediate width
//   func_t         - execute-stage operation code
//   uses_rs2()     - whether an operation reads its second source register
package simple_processor_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned REG_ADDR_WIDTH = $clog2(NUM_REGS);
  localparam int unsigned IMM_WIDTH      = 6;

  // Codes 4..7 are unassigned; they are treated as reading rs1 and rs2.
  typedef enum logic [2:0] {
    SLL  = 3'd0,
    SLLI = 3'd1,
    SLR  = 3'd2,
    SLRI = 3'd3
  } func_t;

  function automatic logic uses_rs2(input func_t func);
    return !((func == SLLI) || (func == SLRI));
  endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: register storage with two combinational read ports and one
// write port. Register 0 is hardwired to zero. A write-back presented in the
// same cycle as a read is forwarded to the read port.
//   clk, rst_n         - clock, synchronous active-low reset (zeros all regs)
//   wb_valid/addr/data - write port
//   rs1_addr, rs1_data - read port A
//   rs2_addr, rs2_data - read port B
module reg_file
  import simple_processor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int unsigned NUM_REGS   = simple_processor_pkg::NUM_REGS,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs2_data
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (wb_valid && (wb_addr == rs1_addr)) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = regs[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (wb_valid && (wb_addr == rs2_addr)) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = regs[rs2_addr];
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: accepts decoded instructions, reads operands (with
// write-back forwarding), stalls on RAW/WAW hazards via a busy-bit
// scoreboard, and presents operands to the execute stage in a single
// registered valid/ready slot.
//   clk_i, rst_ni              - clock, synchronous active-low reset
//   dec_*                      - decoded instruction in (valid/ready)
//   ex_*                       - operands out to the execute stage (valid/ready)
//   wb_valid_i/rd_addr_i/data_i - write-back from the execute stage
module operand_fetch
  import simple_processor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dec_valid_i,
  output logic                  dec_ready_o,
  input  func_t                 dec_func_i,
  input  logic [ADDR_WIDTH-1:0] dec_rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] dec_rs2_addr_i,
  input  logic [ADDR_WIDTH-1:0] dec_rd_addr_i,
  input  logic [IMM_WIDTH-1:0]  dec_imm_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output func_t                 ex_func_o,
  output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
  output logic [IMM_WIDTH-1:0]  ex_imm_o,
  output logic [ADDR_WIDTH-1:0] ex_rd_addr_o,
  input  logic                  wb_valid_i,
  input  logic [ADDR_WIDTH-1:0] wb_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i
);

  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;
  logic [NUM_REGS-1:0]   wb_clear;
  logic [NUM_REGS-1:0]   busy_live;
  logic                  hazard;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_reg_file (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .wb_valid (wb_valid_i),
    .wb_addr  (wb_rd_addr_i),
    .wb_data  (wb_data_i),
    .rs1_addr (dec_rs1_addr_i),
    .rs1_data (rs1_data),
    .rs2_addr (dec_rs2_addr_i),
    .rs2_data (rs2_data)
  );

  always_comb begin
    wb_clear = '0;
    if (wb_valid_i) begin
      wb_clear[wb_rd_addr_i] = 1'b1;
    end
  end

  // A register whose write-back lands this cycle is already resolved: the
  // forwarding path supplies its value, so it must not stall.
  assign busy_live = busy & ~wb_clear;

  always_comb begin
    hazard = busy_live[dec_rs1_addr_i] || busy_live[dec_rd_addr_i];
    if (uses_rs2(dec_func_i) && busy_live[dec_rs2_addr_i]) begin
      hazard = 1'b1;
    end
  end

  assign dec_ready_o = !hazard && (!ex_valid_o || ex_ready_i);
  assign accept      = dec_valid_i && dec_ready_o;

  // Set is applied after clear so a same-cycle set on the same register wins.
  always_comb begin
    busy_next = busy_live;
    if (accept && (dec_rd_addr_i != '0)) begin
      busy_next[dec_rd_addr_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_valid_o    <= 1'b0;
      ex_func_o     <= SLL;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rd_addr_o  <= '0;
    end else if (accept) begin
      ex_valid_o    <= 1'b1;
      ex_func_o     <= dec_func_i;
      ex_rs1_data_o <= rs1_data;
      ex_rs2_data_o <= rs2_data;
      ex_imm_o      <= dec_imm_i;
      ex_rd_addr_o  <= dec_rd_addr_i;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus a randomized run checked against
// a behavioural model of the operand-fetch stage.
module tb_operand_fetch;
  import simple_processor_pkg::*;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dec_valid;
  logic          dec_ready;
  func_t         dec_func;
  logic [AW-1:0] rs1, rs2, rd;
  logic [5:0]    imm;
  logic          ex_valid;
  logic          ex_ready;
  func_t         ex_func;
  logic [DW-1:0] ex_rs1, ex_rs2;
  logic [5:0]    ex_imm;
  logic [AW-1:0] ex_rd;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_fetch #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .dec_valid_i    (dec_valid),
    .dec_ready_o    (dec_ready),
    .dec_func_i     (dec_func),
    .dec_rs1_addr_i (rs1),
    .dec_rs2_addr_i (rs2),
    .dec_rd_addr_i  (rd),
    .dec_imm_i      (imm),
    .ex_valid_o     (ex_valid),
    .ex_ready_i     (ex_ready),
    .ex_func_o      (ex_func),
    .ex_rs1_data_o  (ex_rs1),
    .ex_rs2_data_o  (ex_rs2),
    .ex_imm_o       (ex_imm),
    .ex_rd_addr_o   (ex_rd),
    .wb_valid_i     (wb_valid),
    .wb_rd_addr_i   (wb_addr),
    .wb_data_i      (wb_data)
  );

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  bit            m_valid;
  func_t         m_func;
  logic [DW-1:0] m_rs1, m_rs2;
  logic [5:0]    m_imm;
  logic [AW-1:0] m_rd;

  function automatic bit m_uses_rs2(func_t f);
    return (f != SLLI) && (f != SLRI);
  endfunction

  // A register blocks issue if it is pending and not being written back now.
  function automatic bit m_blocked(logic [AW-1:0] r);
    return (r != 0) && m_busy[r] && !(wb_valid && wb_addr == r);
  endfunction

  function automatic bit m_ready();
    bit haz;
    haz = m_blocked(rs1) || m_blocked(rd) || (m_uses_rs2(dec_func) && m_blocked(rs2));
    return !haz && (!m_valid || ex_ready);
  endfunction

  function automatic logic [DW-1:0] m_read(logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wb_valid && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_valid = 1'b0; m_func = SLL; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_rd = '0;
  endtask

  // Advance one clock edge, updating the model from the inputs held across it.
  task automatic cycle();
    bit acc;
    acc = dec_valid && m_ready();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (acc) begin
        m_valid = 1'b1; m_func = dec_func; m_rs1 = m_read(rs1); m_rs2 = m_read(rs2);
        m_imm = imm; m_rd = rd;
      end else if (ex_ready) begin
        m_valid = 1'b0;
      end
      if (wb_valid) begin
        if (wb_addr != 0) m_regs[wb_addr] = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (acc && rd != 0) m_busy[rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    dec_valid = 1'b0; dec_func = SLL; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    ex_ready = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic issue(func_t f, int a1, int a2, int ad, int im);
    dec_valid = 1'b1; dec_func = f; rs1 = AW'(a1); rs2 = AW'(a2); rd = AW'(ad); imm = 6'(im);
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    idle(); rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1; #1;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
    checks++; if ({ex_rs1, ex_rs2, ex_imm, ex_rd, ex_func} !== '0) begin failures++;
      $display("FAIL reset_ex_fields got=%h_%h_%h_%h_%h exp=0", ex_rs1, ex_rs2, ex_imm, ex_rd, ex_func); end
    checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL reset_dec_ready got=%0b exp=1", dec_ready); end
    issue(SLL, 5, 6, 0, 0); #1;
    cycle(); dec_valid = 1'b0;
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL first_issue_valid got=%0b exp=1", ex_valid); end
    checks++; if ({ex_rs1, ex_rs2} !== 64'h0) begin failures++; $display("FAIL first_issue_ops got=%h_%h exp=0_0", ex_rs1, ex_rs2); end
  endtask

  task automatic test_wb_then_read();
    idle(); wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    cycle(); idle();
    issue(SLR, 3, 0, 0, 0);
    cycle(); dec_valid = 1'b0;
    checks++; if ({ex_rs1, ex_rs2} !== {32'hDEADBEEF, 32'h0}) begin failures++;
      $display("FAIL wb_read_ops got=%h_%h exp=deadbeef_00000000", ex_rs1, ex_rs2); end
    checks++; if (ex_func !== SLR) begin failures++; $display("FAIL wb_read_func got=%0d exp=%0d", ex_func, SLR); end
  endtask

  task automatic test_forward();
    idle(); wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h12345678;
    issue(SLL, 4, 3, 0, 0);
    cycle(); idle();
    checks++; if ({ex_rs1, ex_rs2} !== {32'h12345678, 32'hDEADBEEF}) begin failures++;
      $display("FAIL forward_ops got=%h_%h exp=12345678_deadbeef", ex_rs1, ex_rs2); end
  endtask

  task automatic test_raw_stall();
    idle(); issue(SLL, 0, 0, 7, 0);
    cycle();
    issue(SLL, 7, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL raw_stall_ready got=%0b exp=0", dec_ready); end
      cycle();
    end
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL raw_stall_drained got=%0b exp=0", ex_valid); end
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5; #1;
    checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL raw_release_ready got=%0b exp=1", dec_ready); end
    cycle(); idle();
    checks++; if ({ex_valid, ex_rs1} !== {1'b1, 32'hA5}) begin failures++;
      $display("FAIL raw_release_data got=%0b_%h exp=1_000000a5", ex_valid, ex_rs1); end
  endtask

  task automatic test_backpressure();
    idle(); cycle();
    issue(SLLI, 3, 0, 0, 17); ex_ready = 1'b0;
    cycle();
    issue(SLL, 7, 4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%0b exp=0", dec_ready); end
      cycle();
      checks++; if ({ex_valid, ex_rs1, ex_rs2, ex_imm, ex_rd, ex_func} !== {1'b1, 32'hDEADBEEF, 32'h0, 6'd17, 5'd0, SLLI}) begin
        failures++; $display("FAIL bp_hold got=%0b_%h_%h_%0d_%0d_%0d exp=1_deadbeef_00000000_17_0_1",
                             ex_valid, ex_rs1, ex_rs2, ex_imm, ex_rd, ex_func); end
    end
    ex_ready = 1'b1; #1;
    checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", dec_ready); end
    cycle(); idle();
    checks++; if ({ex_valid, ex_rs1, ex_rs2, ex_func} !== {1'b1, 32'hA5, 32'h12345678, SLL}) begin failures++;
      $display("FAIL bp_next got=%0b_%h_%h_%0d exp=1_000000a5_12345678_0", ex_valid, ex_rs1, ex_rs2, ex_func); end
  endtask

  task automatic test_source_usage();
    idle(); issue(SLL, 0, 0, 9, 0);
    cycle();
    issue(SLLI, 0, 9, 0, 0); #1;
    checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL slli_no_stall got=%0b exp=1", dec_ready); end
    cycle();
    issue(SLL, 0, 9, 0, 0); #1;
    checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL sll_rs2_stall got=%0b exp=0", dec_ready); end
    dec_func = func_t'(3'd6); #1;
    checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL unknown_func_stall got=%0b exp=0", dec_ready); end
    issue(SLLI, 0, 0, 9, 0); #1;
    checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL waw_stall got=%0b exp=0", dec_ready); end
    idle(); wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    cycle(); idle();
    issue(SLL, 0, 9, 0, 0); #1;
    checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL busy_cleared got=%0b exp=1", dec_ready); end
    cycle(); idle();
    checks++; if (ex_rs2 !== 32'h55) begin failures++; $display("FAIL x9_read got=%h exp=00000055", ex_rs2); end
  endtask

  task automatic test_x0();
    idle(); wb_valid = 1'b1; wb_addr = '0; wb_data = 32'hFFFFFFFF;
    issue(SLL, 0, 0, 0, 0);
    cycle(); idle();
    checks++; if ({ex_rs1, ex_rs2} !== 64'h0) begin failures++; $display("FAIL x0_fwd got=%h_%h exp=0_0", ex_rs1, ex_rs2); end
    issue(SLR, 0, 0, 0, 0);
    cycle(); idle();
    checks++; if ({ex_rs1, ex_rs2} !== 64'h0) begin failures++; $display("FAIL x0_read got=%h_%h exp=0_0", ex_rs1, ex_rs2); end
  endtask

  task automatic test_reset_mid_stall();
    idle(); issue(SLL, 3, 4, 10, 5);
    cycle();
    issue(SLL, 10, 0, 0, 0); ex_ready = 1'b0; #1;
    checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL mid_stall_ready got=%0b exp=0", dec_ready); end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    checks++; if ({ex_valid, ex_rs1, ex_rs2, ex_imm, ex_rd, ex_func} !== '0) begin failures++;
      $display("FAIL mid_reset_slot got=%0b_%h_%h_%0d_%0d exp=0", ex_valid, ex_rs1, ex_rs2, ex_imm, ex_rd); end
    checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_busy got=%0b exp=1", dec_ready); end
    cycle();
    issue(SLL, 3, 4, 0, 0); ex_ready = 1'b1;
    cycle(); idle();
    checks++; if ({ex_valid, ex_rs1, ex_rs2} !== {1'b1, 64'h0}) begin failures++;
      $display("FAIL mid_reset_regs got=%0b_%h_%h exp=1_0_0", ex_valid, ex_rs1, ex_rs2); end
  endtask

  // ---------------- randomized run against the model ----------------
  task automatic test_random();
    int accepts = 0;
    idle(); rst_n = 1'b0; cycle(); rst_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      int busy_list [$];
      dec_valid = 1'($urandom_range(0, 1));
      dec_func  = func_t'($urandom_range(0, 7));
      rs1 = AW'($urandom_range(0, 7)); rs2 = AW'($urandom_range(0, 7)); rd = AW'($urandom_range(0, 7));
      imm = 6'($urandom);
      ex_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NR; r++) if (m_busy[r]) busy_list.push_back(r);
      wb_valid = 1'($urandom_range(0, 1));
      wb_data  = $urandom;
      if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
        wb_addr = AW'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      else
        wb_addr = AW'($urandom_range(0, 7));
      #1;
      checks++; if (dec_ready !== m_ready()) begin failures++;
        $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", n, dec_ready, m_ready()); end
      if (dec_valid && dec_ready) accepts++;
      cycle();
      checks++; if (ex_valid !== m_valid) begin failures++;
        $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", n, ex_valid, m_valid); end
      if (m_valid) begin
        checks++; if ({ex_func, ex_rs1, ex_rs2, ex_imm, ex_rd} !== {m_func, m_rs1, m_rs2, m_imm, m_rd}) begin failures++;
          $display("FAIL rnd_slot[%0d] got=%0d_%h_%h_%0d_%0d exp=%0d_%h_%h_%0d_%0d", n,
                   ex_func, ex_rs1, ex_rs2, ex_imm, ex_rd, m_func, m_rs1, m_rs2, m_imm, m_rd); end
      end
    end
    checks++; if (accepts < 50) begin failures++; $display("FAIL rnd_activity got=%0d exp>=50", accepts); end
    idle();
  endtask

  initial begin
    idle(); rst_n = 1'b0; model_reset();
    test_reset();
    test_wb_then_read();
    test_forward();
    test_raw_stall();
    test_backpressure();
    test_source_usage();
    test_x0();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
